spectrum_frame_writer: RTL and testbench
========================================

Name: spectrum_frame_writer

Overview:
- Producer end of the `freq_samples`/`fft_done` interface consumed by the graphics controller.
- Accepts a streamed FFT output frame (complex bins, valid/ready handshake) and computes an approximate magnitude per bin.
- Writes magnitudes into a back bank of a ping-pong buffer, then swaps banks only on a vsync rising edge, so the display never reads a half-written frame (tear-free).
- Sits between the FFT core and the graphics controller in the `clk_25MHz` domain.

Parameters:
- WIDTH, 12, base sample width; bin inputs and magnitudes are WIDTH+2 bits.
- N, 256, bins per frame; must be a power of two, at least 2.

Ports:
- clk_25MHz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  bin beat valid
- in_ready  out  1  block can accept a beat
- in_re  in  WIDTH+2  signed real part
- in_im  in  WIDTH+2  signed imaginary part
- in_last  in  1  marks final bin (index N-1) of a frame
- vsync  in  1  VGA vsync; bank swap point
- freq_samples  out  [WIDTH+1:0] x [0:N-1]  front-bank magnitudes, bin 0 first
- fft_done  out  1  one-cycle pulse, asserted in the cycle new front-bank data first appears
- frame_error  out  1  one-cycle pulse on frame framing error

Behaviour:
- Reset (synchronous): state=FILL, bin index=0, bank_sel=0, both banks all zero, pipeline valid bits cleared, fft_done=0, frame_error=0, vsync history=0.
  - in_ready is 0 during the reset cycle.
  - Reset mid-frame discards the partial frame.
- Handshake: a beat is accepted when in_valid & in_ready. in_ready = (state==FILL || state==SKIP). Input data is ignored when not accepted.
- Magnitude: |re|, |im| taken as unsigned WIDTH+2 (|-2^(WIDTH+1)| = 2^(WIDTH+1)); mag = max + (min>>2) + (min>>3).
  - Maximum value is 11/8 * 2^(WIDTH+1), which fits WIDTH+2 bits, so no saturation is needed.
- Pipeline: 2 stages.
  - S1 registers abs values, index and a last flag on acceptance.
  - S2 computes mag and writes back_bank[index] the cycle after S1, i.e. 2 cycles after acceptance.
- States:
  - FILL: accept beats; index increments per beat.
    - in_last with index==N-1: go to DRAIN.
    - in_last with index<N-1: frame_error pulse; index=0; stay in FILL (back bank contents are don't-care and are overwritten).
    - index==N-1 without in_last: frame_error pulse; go to SKIP.
  - SKIP: accept and drop beats, no writes, until in_last is accepted; then index=0 and go to FILL.
  - DRAIN: in_ready=0; wait until the N-1 write completes; then go to HOLD.
  - HOLD: in_ready=0; on vsync rise (vsync & ~vsync_q, vsync_q registered): toggle bank_sel, pulse fft_done, index=0, go to FILL.
    - A vsync rise in any other state, including the cycle the last write lands, is ignored.
    - Swap happens at the next rise seen in HOLD.
- freq_samples = bank_sel ? bank1 : bank0. Front-bank values change only at a swap; a frame is never partially visible.
- fft_done and frame_error never assert in the same cycle.

Decomposition:
- Package spectrum_pkg:
  - state enum {FILL, SKIP, DRAIN, HOLD}.
  - localparam function for magnitude width (WIDTH+2).
  - index width $clog2(N).
- Sub-module spectrum_mag_approx: abs plus alpha-max-beta-min, combinational; instantiated in S2.

Test Plan:
- Reset, then drive 256 beats with re=bin index, im=0, last on beat 255, toggle vsync → fft_done pulses once on the rise; freq_samples[k]==k; in_ready=0 from DRAIN until the swap.
- Single-bin values → re=300, im=-400 gives 512; re=-8192, im=-8192 gives 11264; re=0, im=-1 gives 1.
- in_last on beat 100 → frame_error pulse; the next full frame swaps normally; freq_samples is unchanged until then.
- 256 beats without in_last, then 3 extra beats with last on the 3rd → frame_error at beat 255; no writes; the next frame is accepted cleanly.
- vsync rise in the same cycle as the final write → no swap; swap and fft_done occur on the following rise.
- Assert rst at beat 128 with a previous frame displayed → all outputs return to zero; bank_sel=0; the next complete frame displays correctly.

Source files
------------

// File: rtl/spectrum_frame_writer_pkg.sv
// rtl/spectrum_frame_writer_pkg.sv - shared types and width helpers for the spectrum frame writer
package spectrum_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SKIP  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Magnitudes and complex bin parts share the same width.
    function automatic int mag_width(input int width);
        return width + 2;
    endfunction

    // Bin index width; a frame has at least two bins.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spectrum_frame_writer_if.sv
// rtl/spectrum_frame_writer_if.sv - complex bin stream from the FFT core
interface spectrum_frame_writer_if #(
    parameter int WIDTH = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [WIDTH+1:0] in_re;
    logic signed [WIDTH+1:0] in_im;

    modport master (
        output in_valid,
        output in_re,
        output in_im,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_re,
        input  in_im,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/spectrum_mag_approx.sv
// rtl/spectrum_mag_approx.sv - alpha-max-plus-beta-min magnitude from absolute parts
module spectrum_mag_approx #(
    parameter int MW = 14
) (
    input  logic [MW-1:0] abs_a_i,
    input  logic [MW-1:0] abs_b_i,
    output logic [MW-1:0] mag_o
);
    logic [MW-1:0] max_v;
    logic [MW-1:0] min_v;

    // max + 3/8 min; the result peaks at 11/8 of the largest absolute part, so it fits MW bits
    always_comb begin
        max_v = (abs_a_i >= abs_b_i) ? abs_a_i : abs_b_i;
        min_v = (abs_a_i >= abs_b_i) ? abs_b_i : abs_a_i;
        mag_o = max_v + (min_v >> 2) + (min_v >> 3);
    end
endmodule

// File: rtl/spectrum_frame_writer.sv
// rtl/spectrum_frame_writer.sv - FFT frame to ping-pong magnitude buffer with vsync-aligned swap
module spectrum_frame_writer
    import spectrum_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                  clk_25MHz,
    input  logic                  rst,
    spectrum_frame_writer_if.slave in_bus,
    input  logic                  vsync,
    output logic [WIDTH+1:0]      freq_samples [0:N-1],
    output logic                  fft_done,
    output logic                  frame_error
);
    localparam int MW = mag_width(WIDTH);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            bank_sel_q, bank_sel_d;
    logic            fft_done_q, fft_done_d;
    logic            frame_error_q, frame_error_d;
    logic            vsync_q;
    logic            s1_load;

    logic            s1_valid_q;
    logic            s1_last_q;
    logic [IW-1:0]   s1_idx_q;
    logic [MW-1:0]   s1_abs_re_q;
    logic [MW-1:0]   s1_abs_im_q;

    logic [MW-1:0]   bank0_q [0:N-1];
    logic [MW-1:0]   bank1_q [0:N-1];

    logic [MW-1:0]   re_u, im_u;
    logic [MW-1:0]   abs_re, abs_im;
    logic [MW-1:0]   mag;
    logic            accept;
    logic            vsync_rise;
    logic            idx_at_last;

    assign in_bus.in_ready = ~rst & ((state_q == FILL) | (state_q == SKIP));
    assign accept          = in_bus.in_valid & in_bus.in_ready;
    assign vsync_rise      = vsync & ~vsync_q;
    assign idx_at_last     = (idx_q == LAST_IDX);
    assign fft_done        = fft_done_q;
    assign frame_error     = frame_error_q;

    // Two's-complement absolute value; the most negative input maps to 2^(MW-1) unsigned
    always_comb begin
        re_u   = in_bus.in_re;
        im_u   = in_bus.in_im;
        abs_re = re_u[MW-1] ? (~re_u + 1'b1) : re_u;
        abs_im = im_u[MW-1] ? (~im_u + 1'b1) : im_u;
    end

    spectrum_mag_approx #(
        .MW (MW)
    ) u_mag (
        .abs_a_i (s1_abs_re_q),
        .abs_b_i (s1_abs_im_q),
        .mag_o   (mag)
    );

    // Frame sequencing: fill the back bank, resync on framing errors, hold until vsync swaps banks
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bank_sel_d    = bank_sel_q;
        fft_done_d    = 1'b0;
        frame_error_d = 1'b0;
        s1_load       = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    s1_load = 1'b1;
                    if (in_bus.in_last) begin
                        idx_d = '0;
                        if (idx_at_last) begin
                            state_d = DRAIN;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end else if (idx_at_last) begin
                        frame_error_d = 1'b1;
                        idx_d         = '0;
                        state_d       = SKIP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SKIP: begin
                if (accept && in_bus.in_last) begin
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (s1_valid_q && s1_last_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (vsync_rise) begin
                    bank_sel_d = ~bank_sel_q;
                    fft_done_d = 1'b1;
                    idx_d      = '0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Control state, bank select, output pulses and vsync history
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= '0;
            bank_sel_q    <= 1'b0;
            fft_done_q    <= 1'b0;
            frame_error_q <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            bank_sel_q    <= bank_sel_d;
            fft_done_q    <= fft_done_d;
            frame_error_q <= frame_error_d;
            vsync_q       <= vsync;
        end
    end

    // Stage 1: capture absolute parts and target bin of each accepted FILL beat
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_idx_q    <= '0;
            s1_abs_re_q <= '0;
            s1_abs_im_q <= '0;
        end else begin
            s1_valid_q <= s1_load;
            if (s1_load) begin
                s1_last_q   <= in_bus.in_last & idx_at_last;
                s1_idx_q    <= idx_q;
                s1_abs_re_q <= abs_re;
                s1_abs_im_q <= abs_im;
            end
        end
    end

    // Stage 2: write the magnitude into whichever bank is not on display
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                bank0_q[k] <= '0;
                bank1_q[k] <= '0;
            end
        end else if (s1_valid_q) begin
            if (bank_sel_q) begin
                bank0_q[s1_idx_q] <= mag;
            end else begin
                bank1_q[s1_idx_q] <= mag;
            end
        end
    end

    // Front bank to the graphics controller
    always_comb begin
        for (int k = 0; k < N; k++) begin
            freq_samples[k] = bank_sel_q ? bank1_q[k] : bank0_q[k];
        end
    end
endmodule

// File: tb/tb_spectrum_frame_writer.sv
// tb/tb_spectrum_frame_writer.sv - self-checking bench for spectrum_frame_writer
module tb_spectrum_frame_writer;
    localparam int WIDTH = 12;
    localparam int N     = 256;
    localparam int MW    = WIDTH + 2;

    logic          clk_25MHz = 1'b0;
    logic          rst;
    logic          vsync;
    logic [MW-1:0] freq_samples [0:N-1];
    logic          fft_done;
    logic          frame_error;

    spectrum_frame_writer_if #(.WIDTH(WIDTH)) bus ();

    spectrum_frame_writer #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .rst          (rst),
        .in_bus       (bus.slave),
        .vsync        (vsync),
        .freq_samples (freq_samples),
        .fft_done     (fft_done),
        .frame_error  (frame_error)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;

    int mdl_back  [N];
    int mdl_front [N];
    int frame_re  [N];
    int frame_im  [N];

    always @(posedge clk_25MHz) begin
        #1;
        if (fft_done) done_cnt++;
        if (frame_error) ferr_cnt++;
        if (fft_done && frame_error) both_cnt++;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_mag(input int re, input int im);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    function automatic int rand_part();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    task automatic check_front(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s[%0d]", tag, k), int'(freq_samples[k]), mdl_front[k]);
        end
    endtask

    task automatic send_beat(input int re, input int im, input bit last);
        int waited;
        waited = 0;
        if ($urandom_range(0, 7) == 0) @(negedge clk_25MHz);
        bus.in_re    = MW'(re);
        bus.in_im    = MW'(im);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk_25MHz);
            waited++;
        end
        check("ready_within_bound", int'(waited < 20), 1);
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_re    = MW'($urandom);
        bus.in_im    = MW'($urandom);
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < N; k++) begin
            frame_re[k] = rand_part();
            frame_im[k] = rand_part();
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < N; k++) begin
            mdl_back[k] = ref_mag(frame_re[k], frame_im[k]);
            send_beat(frame_re[k], frame_im[k], k == N - 1);
        end
    endtask

    task automatic do_swap(input string tag);
        int d0;
        d0 = done_cnt;
        @(negedge clk_25MHz);
        vsync = 1'b1;
        @(negedge clk_25MHz);
        check({tag, "_fft_done_hi"}, int'(fft_done), 1);
        check({tag, "_done_count"}, done_cnt, d0 + 1);
        check({tag, "_ready_after_swap"}, int'(bus.in_ready), 1);
        mdl_front = mdl_back;
        check_front(tag);
        vsync = 1'b0;
        @(negedge clk_25MHz);
        check({tag, "_fft_done_lo"}, int'(fft_done), 0);
    endtask

    initial begin
        int d0, fe0;

        rst          = 1'b1;
        vsync        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        for (int k = 0; k < N; k++) begin
            mdl_back[k]  = 0;
            mdl_front[k] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk_25MHz);
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_fft_done", int'(fft_done), 0);
        check("reset_frame_error", int'(frame_error), 0);
        check_front("reset_front");
        rst = 1'b0;
        @(negedge clk_25MHz);
        check("post_reset_ready", int'(bus.in_ready), 1);

        // Ramp frame: bin k carries re=k, im=0
        for (int k = 0; k < N; k++) begin
            frame_re[k] = k;
            frame_im[k] = 0;
        end
        send_frame();
        check("drain_ready", int'(bus.in_ready), 0);
        repeat (4) @(negedge clk_25MHz);
        check("hold_ready", int'(bus.in_ready), 0);
        check_front("ramp_pre_swap");
        do_swap("ramp");
        check("ramp_bin_255", int'(freq_samples[255]), 255);

        // Known single-bin magnitudes among random bins
        randomize_frame();
        frame_re[0] = 300;   frame_im[0] = -400;
        frame_re[1] = -8192; frame_im[1] = -8192;
        frame_re[2] = 0;     frame_im[2] = -1;
        send_frame();
        repeat (2) @(negedge clk_25MHz);
        do_swap("known");
        check("known_bin0", int'(freq_samples[0]), 512);
        check("known_bin1", int'(freq_samples[1]), 11264);
        check("known_bin2", int'(freq_samples[2]), 1);

        // Short frame: in_last on beat 100
        fe0 = ferr_cnt;
        for (int k = 0; k < 100; k++) send_beat(rand_part(), rand_part(), 1'b0);
        check("short_no_early_error", ferr_cnt, fe0);
        send_beat(rand_part(), rand_part(), 1'b1);
        check("short_error_pulse", ferr_cnt, fe0 + 1);
        check("short_stays_fill", int'(bus.in_ready), 1);
        check_front("short_front_kept");
        randomize_frame();
        send_frame();
        check("short_recover_no_error", ferr_cnt, fe0 + 1);
        check_front("short_recover_pre_swap");
        do_swap("short_recover");

        // Long frame: 256 beats without in_last, then 3 more with last on the 3rd
        fe0 = ferr_cnt;
        for (int k = 0; k < N - 1; k++) send_beat(rand_part(), rand_part(), 1'b0);
        check("long_no_early_error", ferr_cnt, fe0);
        send_beat(rand_part(), rand_part(), 1'b0);
        check("long_error_pulse", ferr_cnt, fe0 + 1);
        check("long_skip_ready", int'(bus.in_ready), 1);
        send_beat(rand_part(), rand_part(), 1'b0);
        send_beat(rand_part(), rand_part(), 1'b0);
        send_beat(rand_part(), rand_part(), 1'b1);
        check("long_single_error", ferr_cnt, fe0 + 1);
        check_front("long_front_kept");
        d0 = done_cnt;
        vsync = 1'b1;
        repeat (2) @(negedge clk_25MHz);
        vsync = 1'b0;
        @(negedge clk_25MHz);
        check("vsync_in_fill_no_done", done_cnt, d0);
        check_front("vsync_in_fill_front");
        randomize_frame();
        send_frame();
        check("long_recover_no_error", ferr_cnt, fe0 + 1);
        do_swap("long_recover");

        // vsync rises in the cycle the final write lands: no swap until the next rise
        d0 = done_cnt;
        randomize_frame();
        send_frame();
        vsync = 1'b1;
        repeat (4) @(negedge clk_25MHz);
        check("late_rise_no_done", done_cnt, d0);
        check("late_rise_hold_ready", int'(bus.in_ready), 0);
        check_front("late_rise_front_kept");
        vsync = 1'b0;
        @(negedge clk_25MHz);
        do_swap("late_rise");
        check("late_rise_one_done", done_cnt, d0 + 1);

        // Reset at beat 128 with a frame on display
        for (int k = 0; k < 128; k++) send_beat(rand_part(), rand_part(), 1'b0);
        rst = 1'b1;
        @(negedge clk_25MHz);
        check("midreset_in_ready", int'(bus.in_ready), 0);
        check("midreset_fft_done", int'(fft_done), 0);
        check("midreset_frame_error", int'(frame_error), 0);
        for (int k = 0; k < N; k++) begin
            mdl_back[k]  = 0;
            mdl_front[k] = 0;
        end
        check_front("midreset_front");
        rst = 1'b0;
        @(negedge clk_25MHz);
        check("midreset_ready_after", int'(bus.in_ready), 1);
        randomize_frame();
        send_frame();
        check_front("midreset_pre_swap");
        do_swap("midreset_recover");

        check("never_both_pulses", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
